ti_payload_ctrl: RTL

- Parametrised, counter-triggered payload controller for the trojan-instrumented FSM benchmark set.
- Sits between a host Mealy FSM's combinational output vector and the module outputs. Watches the host present-state and a trigger condition, counts trigger events, then corrupts the output vector.
- Generalises the fixed "count to 5, zero the outputs" scheme: configurable threshold, corruption mode, scope and duration, plus observability ports for detection experiments.

---
 rtl/ti_pkg.sv | 37 +++
 rtl/ti_payload_ctrl_sat_counter.sv | 26 ++
 rtl/ti_payload_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ti_pkg.sv
// Shared types and helpers for the counter-triggered payload controller.
package ti_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    PAYLOAD = 2'd2
  } ti_state_e;

  localparam int MODE_ZERO = 0;
  localparam int MODE_INV  = 1;
  localparam int MODE_HOLD = 2;

  // Widest output vector the corruption helper handles; callers zero-extend
  // their vectors into it and truncate the result back.
  localparam int TI_MAX_W = 64;

  // Corrupted version of y: masked bits forced to zero, inverted, or taken
  // from the last clean value. Unknown modes leave y untouched.
  function automatic logic [TI_MAX_W-1:0] ti_corrupt(
    input logic [TI_MAX_W-1:0] y,
    input logic [TI_MAX_W-1:0] mask,
    input logic [TI_MAX_W-1:0] hold,
    input int                  mode
  );
    logic [TI_MAX_W-1:0] r;
    r = y;
    case (mode)
      MODE_ZERO: r = y & ~mask;
      MODE_INV:  r = y ^ mask;
      MODE_HOLD: r = (y & ~mask) | (hold & mask);
      default:   r = y;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ti_payload_ctrl_sat_counter.sv
// Saturating up-counter with sync clear and async reset. Clocked on the
// falling edge so it stays in step with the host FSM it shadows.
module ti_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = '1;

  // Clear beats increment; increment stops at all-ones instead of wrapping.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/ti_payload_ctrl.sv
// Counter-triggered payload controller: counts qualified host events and,
// once the threshold event arrives, corrupts the host output vector.
//
// state   | meaning
// IDLE    | no events counted, outputs clean
// COUNT   | 1..THRESH-1 events seen, outputs clean
// PAYLOAD | threshold reached, corruption active per SCOPE
module ti_payload_ctrl
  import ti_pkg::*;
#(
  parameter int               OUT_W      = 20,
  parameter int               STATE_W    = 5,
  parameter int               TRIG_STATE = 9,
  parameter int               THRESH     = 5,
  parameter int               CNT_W      = 8,
  parameter int               MODE       = 0,
  parameter logic [OUT_W-1:0] MASK       = '1,
  parameter int               SCOPE      = 0,
  parameter int               DURATION   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [STATE_W-1:0] pr_state,
  input  logic               trig_cond,
  input  logic [OUT_W-1:0]   y_in,
  output logic [OUT_W-1:0]   y_out,
  output logic [CNT_W-1:0]   trig_cnt,
  output logic               fired
);

  localparam int               DUR_W     = $clog2(DURATION + 2);
  localparam bit               DUR_EN    = (DURATION != 0);
  localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(THRESH - 1);
  localparam logic [DUR_W-1:0] DUR_LAST  = DUR_W'((DURATION == 0) ? 0 : DURATION - 1);

  ti_state_e          state_q;
  ti_state_e          state_d;
  logic               ev;
  logic               arm_now;
  logic               expire;
  logic               illegal;
  logic               corrupt;
  logic               cnt_clr;
  logic               dur_inc;
  logic               dur_clr;
  logic [DUR_W-1:0]   dur_cnt;
  logic [OUT_W-1:0]   hold_q;

  assign ev = en & trig_cond & (pr_state == STATE_W'(TRIG_STATE));

  // Next-state decode; arming and duration expiry are decided here so the
  // counters and corruption logic share one view of them.
  always_comb begin
    state_d = state_q;
    arm_now = 1'b0;
    expire  = 1'b0;
    illegal = 1'b0;
    case (state_q)
      IDLE, COUNT: begin
        arm_now = ev & (trig_cnt == THRESH_M1);
        if (arm_now) begin
          state_d = PAYLOAD;
        end else if (ev) begin
          state_d = COUNT;
        end
      end
      PAYLOAD: begin
        expire = DUR_EN & en & (dur_cnt == DUR_LAST);
        if (expire) begin
          state_d = IDLE;
        end
      end
      default: begin
        illegal = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State register, falling edge like the host FSM.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Expiry wins over a coincident event: the count is cleared, not bumped.
  assign cnt_clr = expire | illegal;
  assign dur_inc = (state_q == PAYLOAD) & en & DUR_EN & ~expire;
  assign dur_clr = expire | illegal;

  ti_sat_counter #(.W(CNT_W)) u_evt_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ev),
    .clr (cnt_clr),
    .cnt (trig_cnt)
  );

  ti_sat_counter #(.W(DUR_W)) u_dur_cnt (
    .clk (clk),
    .rst (rst),
    .inc (dur_inc),
    .clr (dur_clr),
    .cnt (dur_cnt)
  );

  assign fired = (state_q == PAYLOAD);

  // Reset gates corruption so the outputs go clean the moment rst rises,
  // even if an arming condition is present on the inputs.
  assign corrupt = ~rst & (arm_now | (fired & ((SCOPE == 0) ? ev : 1'b1)));

  // Last clean output, used as the replacement value in hold mode.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
    end else if (!corrupt) begin
      hold_q <= y_in;
    end
  end

  assign y_out = corrupt ? OUT_W'(ti_corrupt(TI_MAX_W'(y_in), TI_MAX_W'(MASK),
                                             TI_MAX_W'(hold_q), MODE))
                         : y_in;

endmodule
